sim_pattern_gen: RTL and testbench
==================================

# sim_pattern_gen

Parametrised stimulus source for the DDR FIFO datapath, superseding the fixed 32-bit free-running counter generator. Emits bursts of test patterns on a valid/ready stream into the FIFO write side, honours backpressure, and supports four pattern modes, programmable burst length and clean stop. Used in simulation and on-board bring-up to exercise the DDR FIFO end to end.

## Interface
- DATA_W, 32: output data width; multiple of 32.
- LEN_W, 16: width of burst length and beat counter.
- SEED, 32'h1: LFSR seed; must be nonzero.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion synchronous to clk.
- start  in  1  level; rising edge (start=1, previous sample 0) launches a burst.
- stop  in  1  level; synchronous request to end a running burst.
- mode  in  2  pattern select: 0 counter, 1 PRBS32, 2 walking-one, 3 checkerboard.
- burst_len  in  LEN_W  beats per burst; 0 = continuous until stop.
- out_data  out  DATA_W  pattern beat.
- out_valid  out  1  beat present.
- out_ready  in  1  downstream accepts beat (FIFO not full).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a burst ends (length reached or stop).
- beat_cnt  out  LEN_W  beats accepted in current burst; wraps in continuous mode.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start edge -> latch mode and burst_len, reset pattern state, beat_cnt=0 -> RUN. Edges arriving in RUN or DONE are ignored (edge detector still tracks start).
- RUN: out_valid=1. Accept = out_valid && out_ready. On accept: beat_cnt+1, pattern advances.
- Burst end: accept of beat number burst_len (beat_cnt reaches burst_len) -> DONE; out_valid drops same edge.
- stop in RUN: if no beat pending (out_valid && !out_ready false that cycle) -> DONE next edge; if beat stalled, hold it until accepted, then DONE. No presented beat is ever withdrawn.
- DONE: done=1 for one cycle, out_valid=0 -> IDLE.
- Patterns (initial value at launch, then per accepted beat):
  - counter: 8-bit c, 0 then c+1 mod 256; out_data = c replicated DATA_W/8 times (0xFF -> 0x00 wrap).
  - PRBS32: Galois LFSR x^32+x^22+x^2+x+1, initial SEED; out_data = LFSR replicated DATA_W/32 times.
  - walking-one: bit 0 set, shifts left one per beat, bit DATA_W-1 wraps to bit 0.
  - checkerboard: 0x55.. then 0xAA.., alternating.
- mode/burst_len changes during RUN have no effect.
- While out_valid && !out_ready: out_data and out_valid stable.

## Timing
- Reset values: out_data=0, out_valid=0, busy=0, done=0, beat_cnt=0, state IDLE, start history=0.
- Start edge sampled at edge k -> out_valid=1 and first beat after edge k+1 (1-cycle latency); busy rises same edge.
- Sustained out_ready=1: one beat per cycle, no bubbles.
- Last accept at edge m -> out_valid=0, done=1 after m; done=0, IDLE after m+1. Next start edge accepted from IDLE only.
- Reset mid-burst: all outputs to reset values immediately; no done pulse.
- beat_cnt is LEN_W bits, wraps to 0 in continuous mode; burst_len terminates only on exact match.

## Configuration
- SIM_PATTERN_GEN_ERR_INJ_EN defined: extra input err_inj (1 bit). A pulse arms a flag; next accepted beat has out_data bit 0 inverted, flag clears; pattern state unaffected. Flag cleared by reset and at launch.
- Undefined: err_inj port absent, output always clean pattern.

## Structure
- Package sim_pattern_pkg: mode encodings, state enum, LFSR tap constant 32'h80200003, checkerboard constants.
- One sub-module: pattern_lfsr32 (load seed, advance enable, 32-bit state out).
- Top holds edge detector, FSM, counters, output register.

## Test plan
- Reset mid-RUN (mode 0, burst_len 0) -> out_valid=0, beat_cnt=0 immediately; no done.
- mode 0, burst_len 4, out_ready=1 -> beats 0x00000000, 0x01010101, 0x02020202, 0x03030303 on consecutive cycles, done one cycle after last, beat_cnt=4.
- mode 1, SEED=1, burst_len 3, out_ready toggling 1/0 -> 3 accepted beats equal reference LFSR sequence; data stable across stalls.
- mode 2, DATA_W=64, burst_len 66 -> bit 0..63 walk, beat 64 = bit 0 again; counter mode burst 300 shows 0xFF->0x00 wrap.
- mode 3, burst_len 0, stop asserted while out_ready=0 -> stalled 0xAA.. beat held, accepted when ready=1, then done, IDLE; start edge during RUN ignored.
- With SIM_PATTERN_GEN_ERR_INJ_EN, mode 0, err_inj pulse before beat 2 -> beat 2 = 0x02020203, beat 3 = 0x03030303.

Source files
------------

// File: rtl/sim_pattern_pkg.sv
// Shared encodings and constants for the DDR FIFO pattern generator.
// Holds pattern modes, FSM states, LFSR taps and checkerboard words.
package sim_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_CNT  = 2'd0,
    MODE_PRBS = 2'd1,
    MODE_WALK = 2'd2,
    MODE_CHK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Galois form of x^32+x^22+x^2+x+1, shifting right
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [31:0] CHK_EVEN  = 32'h55555555;
  localparam logic [31:0] CHK_ODD   = 32'hAAAAAAAA;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/pattern_lfsr32.sv
// 32-bit Galois PRBS register: reloads SEED on load, steps once per adv.
// The value held is the word currently presented in PRBS mode.
module pattern_lfsr32
  import sim_pattern_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    state <= SEED;
    else if (load) state <= SEED;
    else if (adv)  state <= lfsr_step(state);
  end

endmodule

// File: rtl/sim_pattern_gen.sv
// Burst pattern source for the DDR FIFO write side (valid/ready, 4 modes).
// Optional SIM_PATTERN_GEN_ERR_INJ_EN adds err_inj to flip bit 0 of one beat.
module sim_pattern_gen
  import sim_pattern_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter int          LEN_W  = 16,
  parameter logic [31:0] SEED   = 32'h1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  burst_len,
`ifdef SIM_PATTERN_GEN_ERR_INJ_EN
  input  logic              err_inj,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  beat_cnt
);

  localparam int NB = DATA_W / 8;
  localparam int NW = DATA_W / 32;

  state_e             state_q, state_n;
  logic               start_q, start_p, start_edge;
  logic               launch, accept, last, fin, inj;
  mode_e              mode_r, md;
  logic [LEN_W-1:0]   len_r, beat_inc;
  logic               stop_pend;
  logic [7:0]         cnt_q, cnt_n;
  logic [DATA_W-1:0]  walk_q, walk_n, pat;
  logic               chk_q, chk_n;
  logic [31:0]        lfsr_q, lfsr_n;

  assign start_edge = start_q & ~start_p;
  assign launch     = (state_q == ST_IDLE) && start_edge;
  assign accept     = (state_q == ST_RUN) && out_ready;
  assign beat_inc   = beat_cnt + 1'b1;
  assign last       = (len_r != '0) && (beat_inc == len_r);
  // stop ends the burst only on an accept, so a stalled beat is never dropped
  assign fin        = accept && (last || stop || stop_pend);

  assign busy      = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_n = ST_RUN;
      ST_RUN:  if (fin)    state_n = ST_DONE;
      ST_DONE:             state_n = ST_IDLE;
      default:             state_n = ST_IDLE;
    endcase
  end

  pattern_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (launch),
    .adv   (accept),
    .state (lfsr_q)
  );

  // Next beat to present: the initial word at launch, else the advanced word
  always_comb begin
    md     = launch ? mode_e'(mode) : mode_r;
    cnt_n  = launch ? 8'd0 : cnt_q + 8'd1;
    walk_n = launch ? {{(DATA_W-1){1'b0}}, 1'b1}
                    : {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
    chk_n  = launch ? 1'b0 : ~chk_q;
    lfsr_n = launch ? SEED : lfsr_step(lfsr_q);
    pat    = '0;
    case (md)
      MODE_CNT:  pat = {NB{cnt_n}};
      MODE_PRBS: pat = {NW{lfsr_n}};
      MODE_WALK: pat = walk_n;
      MODE_CHK:  pat = {NW{chk_n ? CHK_ODD : CHK_EVEN}};
      default:   pat = '0;
    endcase
  end

`ifdef SIM_PATTERN_GEN_ERR_INJ_EN
  logic err_flag;

  // Corrupt only a beat that will actually be presented after this accept
  assign inj = accept && !fin && (err_flag || err_inj);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_flag <= 1'b0;
    else if (launch)  err_flag <= 1'b0;
    else if (inj)     err_flag <= 1'b0;
    else if (err_inj) err_flag <= 1'b1;
  end
`else
  assign inj = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      start_p   <= 1'b0;
      mode_r    <= MODE_CNT;
      len_r     <= '0;
      stop_pend <= 1'b0;
      beat_cnt  <= '0;
      cnt_q     <= 8'd0;
      walk_q    <= '0;
      chk_q     <= 1'b0;
      out_data  <= '0;
    end else begin
      start_q <= start;
      start_p <= start_q;
      if (launch) begin
        mode_r    <= mode_e'(mode);
        len_r     <= burst_len;
        stop_pend <= 1'b0;
        beat_cnt  <= '0;
      end else if (state_q == ST_RUN) begin
        if (accept)         beat_cnt  <= beat_inc;
        if (stop && !accept) stop_pend <= 1'b1;
      end
      if (launch || accept) begin
        cnt_q    <= cnt_n;
        walk_q   <= walk_n;
        chk_q    <= chk_n;
        out_data <= pat ^ {{(DATA_W-1){1'b0}}, inj};
      end
    end
  end

endmodule

// File: tb/tb_sim_pattern_gen.sv
// Self-checking bench for sim_pattern_gen (DATA_W=64) against a pattern model.
module tb_sim_pattern_gen;

  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, out_ready;
  logic [1:0]    mode;
  logic [LW-1:0] burst_len;
  logic [DW-1:0] out_data;
  logic          out_valid, busy, done;
  logic [LW-1:0] beat_cnt;
`ifdef SIM_PATTERN_GEN_ERR_INJ_EN
  logic          err_inj;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_pattern_gen #(.DATA_W(DW), .LEN_W(LW), .SEED(32'h1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .burst_len (burst_len),
`ifdef SIM_PATTERN_GEN_ERR_INJ_EN
    .err_inj   (err_inj),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .beat_cnt  (beat_cnt)
  );

  // Beat k of a burst, straight from the pattern definitions
  function automatic logic [DW-1:0] exp_beat(input int md, input int k);
    logic [31:0] s;
    logic [7:0]  b;
    s = 32'h1;
    b = k[7:0];
    case (md)
      0: return {8{b}};
      1: begin
        for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
        return {2{s}};
      end
      2: return 64'd1 << (k % 64);
      default: return (k % 2 == 1) ? {16{4'hA}} : {16{4'h5}};
    endcase
  endfunction

  // Start edge at the first negedge's following posedge; returns with beat 0 presented
  task automatic launch(input int md, input int len);
    @(negedge clk);
    mode = md[1:0]; burst_len = len[LW-1:0]; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    mode = 2'd0; burst_len = '0;
`ifdef SIM_PATTERN_GEN_ERR_INJ_EN
    err_inj = 1'b0;
`endif
    #2;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || beat_cnt !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%b busy=%b done=%b cnt=%0d data=%h, required all zero",
               out_valid, busy, done, beat_cnt, out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_counter();
    int k, cyc;
    @(negedge clk);
    mode = 2'd0; burst_len = 16'd4; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL start_latency busy=%b valid=%b one edge after start, required 0", busy, out_valid);
    end
    start = 1'b0;
    @(negedge clk);
    k = 0; cyc = 0;
    while (k < 4 && cyc < 20) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== exp_beat(0, k)) begin
        errors++; $display("FAIL cnt_beat k=%0d valid=%b data=%h, required 1 %h", k, out_valid, out_data, exp_beat(0, k));
      end
      k++; cyc++;
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || beat_cnt !== 16'd4) begin
      errors++; $display("FAIL cnt_end valid=%b done=%b cnt=%0d, required 0 1 4", out_valid, done, beat_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL cnt_idle done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_prbs_stall();
    int k, cyc;
    launch(1, 3);
    out_ready = 1'b0; k = 0; cyc = 0;
    while (k < 3 && cyc < 50) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_beat(1, k)) begin
        errors++; $display("FAIL prbs_beat k=%0d valid=%b data=%h, required 1 %h", k, out_valid, out_data, exp_beat(1, k));
      end
      if (out_ready) k++;
      @(negedge clk); cyc++;
      out_ready = ~out_ready;
    end
    checks++;
    if (k != 3) begin errors++; $display("FAIL prbs_timeout accepted=%0d, required 3", k); end
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || beat_cnt !== 16'd3) begin
      errors++; $display("FAIL prbs_end valid=%b done=%b cnt=%0d, required 0 1 3", out_valid, done, beat_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_walk_wrap();
    int k, cyc;
    launch(2, 66);
    k = 0; cyc = 0;
    while (k < 66 && cyc < 600) begin
      out_ready = ($urandom_range(0, 3) != 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_beat(2, k)) begin
        errors++; $display("FAIL walk_beat k=%0d data=%h, required %h", k, out_data, exp_beat(2, k));
      end
      if (out_ready) k++;
      @(negedge clk); cyc++;
    end
    checks++;
    if (k != 66 || done !== 1'b1 || beat_cnt !== 16'd66) begin
      errors++; $display("FAIL walk_end accepted=%0d done=%b cnt=%0d, required 66 1 66", k, done, beat_cnt);
    end
    @(negedge clk);
    launch(0, 300);
    out_ready = 1'b1; k = 0;
    while (k < 300) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_beat(0, k)) begin
        errors++; $display("FAIL cnt_wrap k=%0d data=%h, required %h", k, out_data, exp_beat(0, k));
      end
      k++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || beat_cnt !== 16'd300) begin
      errors++; $display("FAIL cnt_wrap_end done=%b cnt=%0d, required 1 300", done, beat_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_stop();
    launch(3, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_data !== exp_beat(3, i)) begin
        errors++; $display("FAIL chk_beat k=%0d data=%h, required %h", i, out_data, exp_beat(3, i));
      end
      @(negedge clk);
    end
    out_ready = 1'b0; stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_beat(3, 3)) begin
        errors++; $display("FAIL stop_hold i=%0d valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_beat(3, 3));
      end
      if (i == 0) start = 1'b1;
      if (i == 1) stop = 1'b0;
      if (i == 2) start = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_beat(3, 3)) begin
      errors++; $display("FAIL stop_release valid=%b data=%h, required 1 %h", out_valid, out_data, exp_beat(3, 3));
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || beat_cnt !== 16'd4) begin
      errors++; $display("FAIL stop_end valid=%b done=%b cnt=%0d, required 0 1 4", out_valid, done, beat_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL start_in_run_ignored busy=%b done=%b, required 0 0", busy, done);
    end
    // stop with the downstream ready: the presented beat is taken and the burst ends
    launch(0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (out_data !== exp_beat(0, i)) begin
        errors++; $display("FAIL cont_beat k=%0d data=%h, required %h", i, out_data, exp_beat(0, i));
      end
      if (i == 5) stop = 1'b1;
      @(negedge clk);
    end
    stop = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || beat_cnt !== 16'd6) begin
      errors++; $display("FAIL cont_stop valid=%b done=%b cnt=%0d, required 0 1 6", out_valid, done, beat_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int md, len, k, cyc;
    for (int b = 0; b < 5; b++) begin
      md = $urandom_range(0, 3);
      len = $urandom_range(1, 7);
      launch(md, len);
      k = 0; cyc = 0;
      while (k < len && cyc < 100) begin
        out_ready = $urandom_range(0, 1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_beat(md, k)) begin
          errors++; $display("FAIL b2b_beat b=%0d md=%0d k=%0d data=%h, required %h", b, md, k, out_data, exp_beat(md, k));
        end
        if (out_ready) k++;
        @(negedge clk); cyc++;
      end
      checks++;
      if (k != len || done !== 1'b1 || beat_cnt !== len[LW-1:0]) begin
        errors++; $display("FAIL b2b_end b=%0d accepted=%0d done=%b cnt=%0d, required %0d 1 %0d", b, k, done, beat_cnt, len, len);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL b2b_pulse b=%0d done=%b busy=%b, required 0 0", b, done, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    launch(0, 0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || beat_cnt !== '0 || out_data !== '0) begin
      errors++; $display("FAIL reset_mid valid=%b busy=%b done=%b cnt=%0d data=%h, required all zero",
                         out_valid, busy, done, beat_cnt, out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_no_done i=%0d done=%b valid=%b, required 0 0", i, done, out_valid);
      end
      @(negedge clk);
    end
  endtask

`ifdef SIM_PATTERN_GEN_ERR_INJ_EN
  task automatic test_err_inj();
    logic [DW-1:0] e;
    launch(0, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = exp_beat(0, k) ^ ((k == 2) ? 64'd1 : 64'd0);
      checks++;
      if (out_data !== e) begin
        errors++; $display("FAIL err_inj_beat k=%0d data=%h, required %h", k, out_data, e);
      end
      err_inj = (k == 1);
      @(negedge clk);
    end
    err_inj = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_counter();
    test_prbs_stall();
    test_walk_wrap();
    test_stop();
    test_back_to_back();
`ifdef SIM_PATTERN_GEN_ERR_INJ_EN
    test_err_inj();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
